stack_rf_p: RTL and testbench

Parametrised operand-stack register file for the next-generation stack machine. It replaces the fixed rf/sc pair with a single block that owns storage, the stack pointer, and fused stack operations. New capabilities are DUP, SWAP, BINOP (pop two, push one), REPL and CLEAR, plus overflow and underflow detection with sticky error flags. It sits between the decoder/ALU datapath and the operand mux network. TOS and NOS feed the ALU inputs directly.

---
 rtl/stack_rf_p_pkg.sv | 34 +++
 rtl/stack_legal_chk.sv | 32 +++
 rtl/stack_rf_p.sv | 122 ++++++++++++
 tb/tb_stack_rf_p.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_rf_p_pkg.sv
// Shared definitions for the parametrised operand-stack register file.
package stack_rf_p_pkg;

  // Default geometry of the operand stack.
  localparam int STACK_WIDTH_DEF = 8;
  localparam int STACK_DEPTH_DEF = 8;

  // Fused stack operations issued by the decoder, one per cycle.
  typedef enum logic [2:0] {
    SOP_NOP   = 3'd0,
    SOP_PUSH  = 3'd1,
    SOP_POP   = 3'd2,
    SOP_BINOP = 3'd3,
    SOP_REPL  = 3'd4,
    SOP_DUP   = 3'd5,
    SOP_SWAP  = 3'd6,
    SOP_CLEAR = 3'd7
  } stack_op_t;

  // Minimum number of valid entries an op needs before it may execute.
  function automatic int unsigned min_entries(input stack_op_t op);
    case (op)
      SOP_POP, SOP_REPL, SOP_DUP: min_entries = 1;
      SOP_BINOP, SOP_SWAP:        min_entries = 2;
      default:                    min_entries = 0;
    endcase
  endfunction

  // True when an op adds one entry to the stack and so can overflow.
  function automatic logic grows_stack(input stack_op_t op);
    grows_stack = (op == SOP_PUSH) || (op == SOP_DUP);
  endfunction

endpackage

// File: rtl/stack_legal_chk.sv
// Combinational legality check for one stack op against the current depth.
// Underflow is evaluated first, so at most one of ovf/unf is ever set.
module stack_legal_chk
  import stack_rf_p_pkg::*;
#(
  parameter int DW = 4
) (
  input  stack_op_t         op,
  input  logic [DW-1:0]     depth,
  input  logic              full,
  output logic              legal,
  output logic              ovf,
  output logic              unf
);

  logic [DW-1:0] need;

  assign need = DW'(min_entries(op));

  // Classify the op as legal, overflowing or underflowing.
  always_comb begin
    ovf = 1'b0;
    unf = 1'b0;
    if (depth < need) begin
      unf = 1'b1;
    end else if (grows_stack(op) && full) begin
      ovf = 1'b1;
    end
    legal = ~(ovf | unf);
  end

endmodule

// File: rtl/stack_rf_p.sv
// Operand-stack register file: storage, depth pointer, fused stack ops and
// sticky overflow/underflow flags. TOS/NOS are masked reads of the storage.
module stack_rf_p
  import stack_rf_p_pkg::*;
#(
  parameter int WIDTH = STACK_WIDTH_DEF,
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int DW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  stack_op_t        op,
  input  logic [WIDTH-1:0] di,
  output logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] nos,
  output logic [DW-1:0]    depth,
  output logic             empty,
  output logic             full,
  output logic             err_ovf,
  output logic             err_unf,
  input  logic             err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic             op_legal, op_ovf, op_unf;
  logic [AW-1:0]    top_idx, sec_idx, nxt_idx;

  // Slot indices relative to the current depth; only used when the op is legal.
  assign top_idx = AW'(depth_q - DW'(1));
  assign sec_idx = AW'(depth_q - DW'(2));
  assign nxt_idx = AW'(depth_q);

  stack_legal_chk #(
    .DW (DW)
  ) u_legal_chk (
    .op    (op),
    .depth (depth_q),
    .full  (full),
    .legal (op_legal),
    .ovf   (op_ovf),
    .unf   (op_unf)
  );

  // Next storage contents and depth for a legal op; illegal ops change nothing.
  always_comb begin
    mem_d   = mem_q;
    depth_d = depth_q;
    if (op_legal) begin
      case (op)
        SOP_PUSH: begin
          mem_d[nxt_idx] = di;
          depth_d        = depth_q + DW'(1);
        end
        SOP_POP: begin
          depth_d = depth_q - DW'(1);
        end
        SOP_BINOP: begin
          mem_d[sec_idx] = di;
          depth_d        = depth_q - DW'(1);
        end
        SOP_REPL: begin
          mem_d[top_idx] = di;
        end
        SOP_DUP: begin
          mem_d[nxt_idx] = mem_q[top_idx];
          depth_d        = depth_q + DW'(1);
        end
        SOP_SWAP: begin
          mem_d[top_idx] = mem_q[sec_idx];
          mem_d[sec_idx] = mem_q[top_idx];
        end
        SOP_CLEAR: begin
          depth_d = '0;
        end
        default: begin
        end
      endcase
    end
  end

  // Sticky flags: err_clr drops them, but a fresh error in the same cycle wins.
  always_comb begin
    err_ovf_d = (err_ovf_q & ~err_clr) | op_ovf;
    err_unf_d = (err_unf_q & ~err_clr) | op_unf;
  end

  // Depth and error flags, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q   <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      depth_q   <= depth_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // Storage is not reset; reset only blocks the pending write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q <= mem_d;
    end
  end

  assign tos     = (depth_q != '0)      ? mem_q[top_idx] : '0;
  assign nos     = (depth_q >= DW'(2))  ? mem_q[sec_idx] : '0;
  assign depth   = depth_q;
  assign empty   = (depth_q == '0);
  assign full    = (depth_q == DW'(DEPTH));
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_stack_rf_p.sv
// Self-checking bench for stack_rf_p (DEPTH=4, WIDTH=8) against a queue model.
module tb_stack_rf_p;
  import stack_rf_p_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DW    = $clog2(DEPTH + 1);
  localparam int VW    = DW + 2 * WIDTH + 4;

  logic             clk;
  logic             reset;
  stack_op_t        op;
  logic [WIDTH-1:0] di;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [DW-1:0]    depth;
  logic             empty;
  logic             full;
  logic             err_ovf;
  logic             err_unf;
  logic             err_clr;

  int n_checks;
  int n_fails;

  // Reference model: the stack as a queue whose last element is the top.
  logic [WIDTH-1:0] mq [$];
  logic             m_ovf;
  logic             m_unf;

  stack_rf_p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .op      (op),
    .di      (di),
    .tos     (tos),
    .nos     (nos),
    .depth   (depth),
    .empty   (empty),
    .full    (full),
    .err_ovf (err_ovf),
    .err_unf (err_unf),
    .err_clr (err_clr)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Apply one cycle of the op rules to the queue model.
  task automatic model_apply(input stack_op_t o, input logic [WIDTH-1:0] d,
                             input logic clr, input logic rst);
    logic             e_ovf;
    logic             e_unf;
    logic [WIDTH-1:0] tmp;
    int               n;
    e_ovf = 1'b0;
    e_unf = 1'b0;
    n     = mq.size();
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      return;
    end
    case (o)
      SOP_PUSH:  if (n < DEPTH) mq.push_back(d); else e_ovf = 1'b1;
      SOP_POP:   if (n >= 1) void'(mq.pop_back()); else e_unf = 1'b1;
      SOP_BINOP: if (n >= 2) begin
                   void'(mq.pop_back());
                   mq[mq.size()-1] = d;
                 end else e_unf = 1'b1;
      SOP_REPL:  if (n >= 1) mq[n-1] = d; else e_unf = 1'b1;
      SOP_DUP:   if (n < 1) e_unf = 1'b1;
                 else if (n >= DEPTH) e_ovf = 1'b1;
                 else mq.push_back(mq[n-1]);
      SOP_SWAP:  if (n >= 2) begin
                   tmp     = mq[n-1];
                   mq[n-1] = mq[n-2];
                   mq[n-2] = tmp;
                 end else e_unf = 1'b1;
      SOP_CLEAR: mq.delete();
      default: ;
    endcase
    if (clr) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (e_ovf) m_ovf = 1'b1;
    if (e_unf) m_unf = 1'b1;
  endtask

  // Expected observable state {depth,tos,nos,empty,full,ovf,unf} from the model.
  function automatic logic [VW-1:0] exp_vec();
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] s;
    int               n;
    n = mq.size();
    t = (n >= 1) ? mq[n-1] : '0;
    s = (n >= 2) ? mq[n-2] : '0;
    exp_vec = {DW'(n), t, s, (n == 0), (n == DEPTH), m_ovf, m_unf};
  endfunction

  // One clock of stimulus; outputs are stable #1 after the edge when this returns.
  task automatic drive(input stack_op_t o, input logic [WIDTH-1:0] d,
                       input logic clr, input logic rst);
    op      = o;
    di      = d;
    err_clr = clr;
    reset   = rst;
    @(posedge clk);
    model_apply(o, d, clr, rst);
    #1;
    op      = SOP_NOP;
    err_clr = 1'b0;
    reset   = 1'b0;
  endtask

  task automatic test_reset();
    drive(SOP_NOP, 8'h00, 1'b0, 1'b1);
    drive(SOP_NOP, 8'h00, 1'b0, 1'b1);
    n_checks++;
    if ({depth, tos, nos, empty, full, err_ovf, err_unf} !== {3'd0, 8'h00, 8'h00, 4'b1000}) begin
      n_fails++;
      $display("[TB] FAIL reset_state: got %h want %h",
               {depth, tos, nos, empty, full, err_ovf, err_unf}, {3'd0, 8'h00, 8'h00, 4'b1000});
    end
  endtask

  task automatic test_push_swap_binop();
    drive(SOP_PUSH, 8'h11, 1'b0, 1'b0);
    drive(SOP_PUSH, 8'h22, 1'b0, 1'b0);
    drive(SOP_PUSH, 8'h33, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos, empty, full} !== {3'd3, 8'h33, 8'h22, 2'b00}) begin
      n_fails++;
      $display("[TB] FAIL push3: got %h want %h", {depth, tos, nos, empty, full},
               {3'd3, 8'h33, 8'h22, 2'b00});
    end
    drive(SOP_SWAP, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos} !== {3'd3, 8'h22, 8'h33}) begin
      n_fails++;
      $display("[TB] FAIL swap: got %h want %h", {depth, tos, nos}, {3'd3, 8'h22, 8'h33});
    end
    drive(SOP_BINOP, 8'h55, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos} !== {3'd2, 8'h55, 8'h11}) begin
      n_fails++;
      $display("[TB] FAIL binop: got %h want %h", {depth, tos, nos}, {3'd2, 8'h55, 8'h11});
    end
  endtask

  task automatic test_overflow();
    drive(SOP_PUSH, 8'hAA, 1'b0, 1'b0);
    drive(SOP_PUSH, 8'hBB, 1'b0, 1'b0);
    drive(SOP_PUSH, 8'hCC, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos, full, err_ovf, err_unf} !== {3'd4, 8'hBB, 8'hAA, 3'b110}) begin
      n_fails++;
      $display("[TB] FAIL push_ovf: got %h want %h", {depth, tos, nos, full, err_ovf, err_unf},
               {3'd4, 8'hBB, 8'hAA, 3'b110});
    end
    drive(SOP_DUP, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos, full, err_ovf, err_unf} !== {3'd4, 8'hBB, 8'hAA, 3'b110}) begin
      n_fails++;
      $display("[TB] FAIL dup_ovf: got %h want %h", {depth, tos, nos, full, err_ovf, err_unf},
               {3'd4, 8'hBB, 8'hAA, 3'b110});
    end
  endtask

  task automatic test_underflow();
    drive(SOP_NOP, 8'h00, 1'b0, 1'b1);
    drive(SOP_POP, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, empty, err_ovf, err_unf} !== {3'd0, 8'h00, 3'b101}) begin
      n_fails++;
      $display("[TB] FAIL pop_unf: got %h want %h", {depth, tos, empty, err_ovf, err_unf},
               {3'd0, 8'h00, 3'b101});
    end
    drive(SOP_PUSH, 8'h01, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos, err_ovf, err_unf} !== {3'd1, 8'h01, 8'h00, 2'b01}) begin
      n_fails++;
      $display("[TB] FAIL push_after_unf: got %h want %h", {depth, tos, nos, err_ovf, err_unf},
               {3'd1, 8'h01, 8'h00, 2'b01});
    end
  endtask

  task automatic test_err_clr();
    drive(SOP_SWAP, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({depth, tos, err_unf} !== {3'd1, 8'h01, 1'b1}) begin
      n_fails++;
      $display("[TB] FAIL clr_vs_error: got %h want %h", {depth, tos, err_unf}, {3'd1, 8'h01, 1'b1});
    end
    drive(SOP_NOP, 8'h00, 1'b1, 1'b0);
    n_checks++;
    if ({err_ovf, err_unf} !== 2'b00) begin
      n_fails++;
      $display("[TB] FAIL clr_alone: got %b want %b", {err_ovf, err_unf}, 2'b00);
    end
  endtask

  task automatic test_dup_clear_reset();
    drive(SOP_REPL, 8'h7E, 1'b0, 1'b0);
    drive(SOP_DUP, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos, err_ovf, err_unf} !== {3'd2, 8'h7E, 8'h7E, 2'b00}) begin
      n_fails++;
      $display("[TB] FAIL dup: got %h want %h", {depth, tos, nos, err_ovf, err_unf},
               {3'd2, 8'h7E, 8'h7E, 2'b00});
    end
    drive(SOP_CLEAR, 8'h00, 1'b0, 1'b0);
    n_checks++;
    if ({depth, tos, nos, empty} !== {3'd0, 8'h00, 8'h00, 1'b1}) begin
      n_fails++;
      $display("[TB] FAIL clear: got %h want %h", {depth, tos, nos, empty}, {3'd0, 8'h00, 8'h00, 1'b1});
    end
    drive(SOP_PUSH, 8'h42, 1'b0, 1'b0);
    drive(SOP_PUSH, 8'h99, 1'b0, 1'b1);
    n_checks++;
    if ({depth, tos, empty} !== {3'd0, 8'h00, 1'b1}) begin
      n_fails++;
      $display("[TB] FAIL reset_over_push: got %h want %h", {depth, tos, empty}, {3'd0, 8'h00, 1'b1});
    end
  endtask

  task automatic test_random();
    stack_op_t o;
    logic      clr;
    logic      rst;
    for (int i = 0; i < 400; i++) begin
      o   = stack_op_t'($urandom_range(0, 7));
      // Skew away from CLEAR so the stack regularly reaches full.
      if (o == SOP_CLEAR && $urandom_range(0, 3) != 0) o = SOP_PUSH;
      clr = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 63) == 0);
      drive(o, WIDTH'($urandom), clr, rst);
      n_checks++;
      if ({depth, tos, nos, empty, full, err_ovf, err_unf} !== exp_vec()) begin
        n_fails++;
        $display("[TB] FAIL random[%0d] op=%0d: got %h want %h", i, o,
                 {depth, tos, nos, empty, full, err_ovf, err_unf}, exp_vec());
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    op       = SOP_NOP;
    di       = '0;
    err_clr  = 1'b0;
    reset    = 1'b1;
    test_reset();
    test_push_swap_binop();
    test_overflow();
    test_underflow();
    test_err_clr();
    test_dup_clear_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
